hcsr04_emulator: RTL and testbench

- Cycle-accurate model of one HC-SR04 ultrasonic module, seen from its pins.
- Accepts a trigger pulse and answers with an echo pulse sized to a programmed distance. Also models the unit's lock-up defect, which only a power cycle clears.
- Runs on a second FPGA or in simulation as the far end of the ultrasound driver. Enables hardware-in-the-loop testing of the rover ranging path without physical sensors.

---
 rtl/hcsr04_emulator.sv | 193 +++++++++++++++++++
 tb/tb_hcsr04_emulator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_emulator.sv
// Pin-level model of one HC-SR04 ultrasonic ranger: trigger in, distance-sized echo out,
// including the lock-up defect that only a long enough power-off clears.
module hcsr04_emulator #(
  parameter int TRIGGER_MIN     = 270,
  parameter int BURST_CYCLES    = 12150,
  parameter int COUNTS_PER_INCH = 3996,
  parameter int MIN_INCHES      = 1,
  parameter int MAX_INCHES      = 160,
  parameter int ECHO_TIMEOUT    = 1026000,
  parameter int HOLDOFF_CYCLES  = 270000,
  parameter int POWERUP_CYCLES  = 2700000,
  parameter int POWER_OFF_MIN   = 13500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       power,
  input  logic       trigger,
  input  logic [7:0] distance_inches,
  input  logic       target_present,
  input  logic       fault_enable,
  output logic       echo,
  output logic       busy,
  output logic       stuck,
  output logic       short_trigger,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    WARMUP    = 3'd1,
    IDLE      = 3'd2,
    TRIG_HIGH = 3'd3,
    BURST     = 3'd4,
    ECHO      = 3'd5,
    HOLDOFF   = 3'd6,
    STUCK     = 3'd7
  } state_t;

  localparam logic [23:0] TRIG_MIN_C = 24'(TRIGGER_MIN);
  localparam logic [23:0] BURST_C    = 24'(BURST_CYCLES);
  localparam logic [23:0] HOLDOFF_C  = 24'(HOLDOFF_CYCLES);
  localparam logic [23:0] POWERUP_C  = 24'(POWERUP_CYCLES);
  localparam logic [23:0] OFF_MIN_C  = 24'(POWER_OFF_MIN);
  localparam logic [19:0] CPI_C      = 20'(COUNTS_PER_INCH);
  localparam logic [19:0] TIMEOUT_C  = 20'(ECHO_TIMEOUT);
  localparam logic [7:0]  MIN_IN_C   = 8'(MIN_INCHES);
  localparam logic [7:0]  MAX_IN_C   = 8'(MAX_INCHES);

  state_t      st;
  logic        trig_s1, trig_s2, trig_s3, trig_rise, trig_fall;
  logic        pwr_s1, pwr_s2;
  logic [23:0] count;
  logic [23:0] off_count;
  logic [19:0] echo_len, echo_count;
  logic        timeout_echo;

  assign state = st;

  // Two-flop synchronizers; trig_s3 is the previous synced value, and the
  // edge pulses are registered so the FSM sees a fall three clocks after the pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_s3   <= 1'b0;
      trig_rise <= 1'b0;
      trig_fall <= 1'b0;
      pwr_s1    <= 1'b0;
      pwr_s2    <= 1'b0;
    end else begin
      trig_s1   <= trigger;
      trig_s2   <= trig_s1;
      trig_s3   <= trig_s2;
      trig_rise <= trig_s2 & ~trig_s3;
      trig_fall <= ~trig_s2 & trig_s3;
      pwr_s1    <= power;
      pwr_s2    <= pwr_s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st            <= OFF;
      echo          <= 1'b0;
      busy          <= 1'b0;
      stuck         <= 1'b0;
      short_trigger <= 1'b0;
      count         <= '0;
      off_count     <= '0;
      echo_len      <= '0;
      echo_count    <= '0;
      timeout_echo  <= 1'b0;
    end else begin
      short_trigger <= 1'b0;
      // Losing supply overrides everything; stuck survives it on purpose.
      if (!pwr_s2) begin
        if (st != OFF) begin
          st        <= OFF;
          echo      <= 1'b0;
          busy      <= 1'b0;
          off_count <= '0;
        end else if (off_count < OFF_MIN_C) begin
          off_count <= off_count + 24'd1;
        end
      end else begin
        unique case (st)
          OFF: begin
            if (off_count >= OFF_MIN_C) stuck <= 1'b0;
            count <= '0;
            st    <= WARMUP;
          end
          WARMUP: begin
            if (count == POWERUP_C - 24'd1) begin
              count <= '0;
              st    <= stuck ? STUCK : IDLE;
            end else begin
              count <= count + 24'd1;
            end
          end
          IDLE: begin
            if (trig_rise) begin
              st    <= TRIG_HIGH;
              count <= 24'd1;
              busy  <= 1'b1;
            end
          end
          TRIG_HIGH: begin
            if (trig_fall) begin
              if (count >= TRIG_MIN_C) begin
                st    <= BURST;
                count <= '0;
              end else begin
                st            <= IDLE;
                busy          <= 1'b0;
                short_trigger <= 1'b1;
              end
            end else if (count < TRIG_MIN_C) begin
              count <= count + 24'd1;
            end
          end
          BURST: begin
            if (count == BURST_C - 24'd1) begin
              // Target inputs are sampled once here and then ignored until the next ping.
              if (target_present && distance_inches >= MIN_IN_C && distance_inches <= MAX_IN_C) begin
                echo_len     <= 20'(distance_inches) * CPI_C;
                timeout_echo <= 1'b0;
              end else begin
                echo_len     <= TIMEOUT_C;
                timeout_echo <= 1'b1;
              end
              echo       <= 1'b1;
              echo_count <= 20'd1;
              count      <= '0;
              st         <= ECHO;
            end else begin
              count <= count + 24'd1;
            end
          end
          ECHO: begin
            if (echo_count >= echo_len) begin
              echo  <= 1'b0;
              count <= '0;
              if (timeout_echo && fault_enable) begin
                stuck <= 1'b1;
                busy  <= 1'b0;
                st    <= STUCK;
              end else begin
                st <= HOLDOFF;
              end
            end else begin
              echo_count <= echo_count + 20'd1;
            end
          end
          HOLDOFF: begin
            if (count == HOLDOFF_C - 24'd1) begin
              count <= '0;
              busy  <= 1'b0;
              st    <= IDLE;
            end else begin
              count <= count + 24'd1;
            end
          end
          STUCK: begin
            echo <= 1'b0;
            busy <= 1'b0;
          end
          default: st <= OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Directed bench for hcsr04_emulator with shortened timing parameters so every
// scenario (timeouts, lock-up, long power-off) fits in a short run.
module tb_hcsr04_emulator;

  localparam int TRIG_MIN = 10;
  localparam int BURST    = 50;
  localparam int CPI      = 20;
  localparam int TIMEOUT  = 4000;
  localparam int HOLDOFF  = 200;
  localparam int POWERUP  = 300;
  localparam int OFF_MIN  = 2000;
  localparam int RISE_DLY = BURST + 3;

  localparam logic [2:0] S_OFF = 3'd0, S_WARMUP = 3'd1, S_IDLE = 3'd2,
                         S_HOLDOFF = 3'd6, S_STUCK = 3'd7;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       power = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] distance_inches = 8'd10;
  logic       target_present = 1'b1;
  logic       fault_enable = 1'b0;
  logic       echo, busy, stuck, short_trigger;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  hcsr04_emulator #(
    .TRIGGER_MIN(TRIG_MIN), .BURST_CYCLES(BURST), .COUNTS_PER_INCH(CPI),
    .MIN_INCHES(1), .MAX_INCHES(160), .ECHO_TIMEOUT(TIMEOUT),
    .HOLDOFF_CYCLES(HOLDOFF), .POWERUP_CYCLES(POWERUP), .POWER_OFF_MIN(OFF_MIN)
  ) dut (
    .clock(clock), .reset(reset), .power(power), .trigger(trigger),
    .distance_inches(distance_inches), .target_present(target_present),
    .fault_enable(fault_enable), .echo(echo), .busy(busy), .stuck(stuck),
    .short_trigger(short_trigger), .state(state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks; inputs change on the falling edge
  task automatic pulse_trigger(input int n);
    @(negedge clock);
    trigger = 1'b1;
    repeat (n) @(negedge clock);
    trigger = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget && state !== s; i++) @(negedge clock);
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_rise(input int budget, output int delay);
    delay = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (echo) begin
        delay = i - 1;
        break;
      end
    end
  endtask

  task automatic measure_width(input int budget, output int width, output int busy_ok);
    width = 0;
    busy_ok = 1;
    while (echo && width < budget) begin
      if (!busy) busy_ok = 0;
      width++;
      @(negedge clock);
    end
  endtask

  task automatic watch(input int cycles, output int echo_hi, output int short_hi);
    echo_hi = 0;
    short_hi = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (echo) echo_hi++;
      if (short_trigger) short_hi++;
    end
  endtask

  // full ping: trigger, latency, width against the scoreboard queue
  task automatic ping(input string tag, input int trig_len, input logic [31:0] exp_width);
    int d, w, b;
    exp_q.push_back(exp_width);
    pulse_trigger(trig_len);
    wait_rise(RISE_DLY + 20, d);
    check({tag, "_delay"}, 32'(d), 32'(RISE_DLY));
    measure_width(TIMEOUT + 100, w, b);
    check({tag, "_width"}, 32'(w), exp_q.pop_front());
    check({tag, "_busy"}, 32'(b), 32'd1);
  endtask

  initial begin
    int d, w, b, e_hi, s_hi;

    #12;
    check("rst_state", 32'(state), 32'(S_OFF));
    check("rst_echo", 32'(echo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    check("rst_short", 32'(short_trigger), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    wait_state("enter_warmup", S_WARMUP, 20);
    pulse_trigger(15);
    watch(10, e_hi, s_hi);
    check("warmup_ignores_trig", 32'(state), 32'(S_WARMUP));
    check("warmup_no_short", 32'(s_hi), 32'd0);
    wait_state("enter_idle", S_IDLE, POWERUP + 20);

    // 10 inches -> 200 clocks
    distance_inches = 8'd10;
    ping("d10", 15, 32'd200);
    check("d10_holdoff", 32'(state), 32'(S_HOLDOFF));
    wait_state("d10_idle", S_IDLE, HOLDOFF + 20);

    // one clock short of the minimum
    pulse_trigger(TRIG_MIN - 1);
    watch(RISE_DLY + 30, e_hi, s_hi);
    check("short_pulse_cnt", 32'(s_hi), 32'd1);
    check("short_no_echo", 32'(e_hi), 32'd0);
    check("short_idle", 32'(state), 32'(S_IDLE));

    // exactly the minimum, smallest distance
    distance_inches = 8'd1;
    ping("d1_minlen", TRIG_MIN, 32'd20);
    wait_state("d1_idle", S_IDLE, HOLDOFF + 20);

    distance_inches = 8'd160;
    ping("d160", 15, 32'd3200);
    wait_state("d160_idle", S_IDLE, HOLDOFF + 20);

    distance_inches = 8'd0;
    ping("d0_timeout", 15, 32'(TIMEOUT));
    wait_state("d0_idle", S_IDLE, HOLDOFF + 20);

    distance_inches = 8'd161;
    ping("d161_timeout", 15, 32'(TIMEOUT));
    check("d161_not_stuck", 32'(stuck), 32'd0);
    wait_state("d161_idle", S_IDLE, HOLDOFF + 20);

    distance_inches = 8'd10;
    target_present = 1'b0;
    ping("notgt_timeout", 15, 32'(TIMEOUT));

    // trigger fully inside holdoff is ignored
    pulse_trigger(15);
    watch(10, e_hi, s_hi);
    check("holdoff_no_short", 32'(s_hi), 32'd0);
    wait_state("holdoff_exit", S_IDLE, HOLDOFF + 20);
    watch(RISE_DLY + 20, e_hi, s_hi);
    check("holdoff_trig_no_echo", 32'(e_hi), 32'd0);
    check("holdoff_trig_idle", 32'(state), 32'(S_IDLE));

    // distance change mid-echo does not alter width
    target_present = 1'b1;
    distance_inches = 8'd20;
    exp_q.push_back(32'd400);
    pulse_trigger(15);
    wait_rise(RISE_DLY + 20, d);
    distance_inches = 8'd100;
    measure_width(TIMEOUT + 100, w, b);
    check("latch_width", 32'(w), exp_q.pop_front());

    // trigger held high across holdoff exit needs a fresh edge
    trigger = 1'b1;
    wait_state("held_idle", S_IDLE, HOLDOFF + 20);
    watch(5, e_hi, s_hi);
    trigger = 1'b0;
    watch(RISE_DLY + 20, e_hi, s_hi);
    check("held_no_echo", 32'(e_hi), 32'd0);
    check("held_no_short", 32'(s_hi), 32'd0);
    check("held_idle2", 32'(state), 32'(S_IDLE));

    // lock-up
    fault_enable = 1'b1;
    target_present = 1'b0;
    ping("fault", 15, 32'(TIMEOUT));
    check("fault_stuck", 32'(stuck), 32'd1);
    check("fault_state", 32'(state), 32'(S_STUCK));
    check("fault_busy", 32'(busy), 32'd0);
    pulse_trigger(15);
    watch(RISE_DLY + 20, e_hi, s_hi);
    check("stuck_no_echo", 32'(e_hi), 32'd0);
    check("stuck_stays", 32'(state), 32'(S_STUCK));

    // brief power cycle keeps the lock-up
    fault_enable = 1'b0;
    target_present = 1'b1;
    power = 1'b0;
    repeat (1000) @(negedge clock);
    power = 1'b1;
    wait_state("short_off_warmup", S_WARMUP, 20);
    wait_state("short_off_stuck", S_STUCK, POWERUP + 20);
    check("short_off_flag", 32'(stuck), 32'd1);

    // long power cycle clears it
    power = 1'b0;
    repeat (OFF_MIN + 100) @(negedge clock);
    power = 1'b1;
    wait_state("long_off_warmup", S_WARMUP, 20);
    check("long_off_cleared", 32'(stuck), 32'd0);
    wait_state("long_off_idle", S_IDLE, POWERUP + 20);
    distance_inches = 8'd10;
    ping("recovered", 15, 32'd200);
    wait_state("recovered_idle", S_IDLE, HOLDOFF + 20);

    // power drop mid-echo
    pulse_trigger(15);
    wait_rise(RISE_DLY + 20, d);
    repeat (50) @(negedge clock);
    power = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pdrop_sync_lat", 32'(echo), 32'd1);
    @(negedge clock);
    check("pdrop_echo", 32'(echo), 32'd0);
    check("pdrop_state", 32'(state), 32'(S_OFF));
    check("pdrop_busy", 32'(busy), 32'd0);
    check("pdrop_stuck", 32'(stuck), 32'd0);
    power = 1'b1;
    wait_state("pdrop_warmup", S_WARMUP, 20);
    wait_state("pdrop_idle", S_IDLE, POWERUP + 20);

    // asynchronous reset mid-echo
    pulse_trigger(15);
    wait_rise(RISE_DLY + 20, d);
    check("rst_mid_rise", 32'(d), 32'(RISE_DLY));
    repeat (20) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_echo", 32'(echo), 32'd0);
    check("arst_state", 32'(state), 32'(S_OFF));
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    wait_state("arst_warmup", S_WARMUP, 20);
    wait_state("arst_idle", S_IDLE, POWERUP + 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
